// File: rtl/jpeg_axi_pkg.sv
// Shared definitions for the JPEG compressor AXI4-Lite block master.
//   - Register byte offsets inside the compressor register block
//   - Top-level FSM state encoding and result component codes
//   - Phase encoding of the single-transaction AXI-Lite engine
//   - res_offset(): maps a result component to its result-window offset
package jpeg_axi_pkg;

  localparam logic [31:0] CTRL_OFF   = 32'h000;
  localparam logic [31:0] STATUS_OFF = 32'h004;
  localparam logic [31:0] RGB_OFF    = 32'h040;
  localparam logic [31:0] Y_OFF      = 32'h240;
  localparam logic [31:0] CB_OFF     = 32'h2C0;
  localparam logic [31:0] CR_OFF     = 32'h340;

  localparam logic [31:0] CTRL_START      = 32'h1;
  localparam int          STATUS_DONE_BIT = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PIX,
    ST_AW_W,
    ST_B,
    ST_CTRL_AW_W,
    ST_CTRL_B,
    ST_POLL_AR,
    ST_POLL_R,
    ST_RD_AR,
    ST_RD_R,
    ST_OUT
  } state_t;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_t;

  typedef enum logic [2:0] {
    XP_IDLE,
    XP_AW_W,
    XP_B,
    XP_AR,
    XP_R
  } xact_phase_t;

  function automatic logic [31:0] res_offset(input comp_t c);
    case (c)
      COMP_Y:  return Y_OFF;
      COMP_CB: return CB_OFF;
      default: return CR_OFF;
    endcase
  endfunction

endpackage

// File: rtl/jpeg_axil_xact.sv
// Single-transaction AXI4-Lite master engine.
// A one-cycle req launches one write (we=1) or one read (we=0); the engine
// then owns the AXI channels until the response handshake, after which it
// pulses ack for one cycle with rdata (reads) and resp_err (non-OKAY resp).
// Only one transaction is ever outstanding; req is ignored while busy.
// Ports:
//   axi_aclk, axi_areset        clock, async active-high reset
//   req, we, addr, wdata        transaction request
//   ack, rdata, resp_err        transaction completion
//   m_axi_*                     AXI4-Lite master channels
module jpeg_axil_xact
  import jpeg_axi_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32
) (
  input  logic                          axi_aclk,
  input  logic                          axi_areset,
  input  logic                          req,
  input  logic                          we,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]   wdata,
  output logic                          ack,
  output logic [C_AXI_DATA_WIDTH-1:0]   rdata,
  output logic                          resp_err,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  xact_phase_t phase;

  // Every write is a full-word write.
  assign m_axi_wstrb = '1;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      phase         <= XP_IDLE;
      ack           <= 1'b0;
      rdata         <= '0;
      resp_err      <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      ack      <= 1'b0;
      resp_err <= 1'b0;
      case (phase)
        XP_IDLE: begin
          if (req) begin
            if (we) begin
              m_axi_awaddr  <= addr;
              m_axi_wdata   <= wdata;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              phase         <= XP_AW_W;
            end else begin
              m_axi_araddr  <= addr;
              m_axi_arvalid <= 1'b1;
              phase         <= XP_AR;
            end
          end
        end
        XP_AW_W: begin
          // AW and W complete independently; leave only once both are taken.
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            phase        <= XP_B;
          end
        end
        XP_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            ack          <= 1'b1;
            resp_err     <= (m_axi_bresp != 2'b00);
            phase        <= XP_IDLE;
          end
        end
        XP_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            phase         <= XP_R;
          end
        end
        XP_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rdata        <= m_axi_rdata;
            ack          <= 1'b1;
            resp_err     <= (m_axi_rresp != 2'b00);
            phase        <= XP_IDLE;
          end
        end
        default: phase <= XP_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/jpeg_axi_block_master.sv
// JPEG compressor block master.
// On start, streams PIXEL_COUNT RGB pixels into the compressor's RGB window
// (one AXI-Lite write per component), writes CTRL=1, polls STATUS until the
// done bit (bit 1) is set, then reads RES_COUNT Y, Cb and Cr result words and
// presents them on a valid/ready result stream. Any non-OKAY AXI response
// sets the sticky error flag and abandons the block.
// Optional build macro: JPEG_AXIM_POLL_TIMEOUT_EN -- when defined, POLL_LIMIT
// not-done status reads end the block with error; otherwise polling never
// gives up.
// Ports:
//   axi_aclk, axi_areset              clock, async active-high reset
//   start / busy / done / error       block control and status
//   pix_valid/pix_ready/pix_r,g,b     input pixel stream
//   res_valid/res_ready/res_data/
//   res_comp/res_index                output result stream
//   m_axi_*                           AXI4-Lite master
module jpeg_axi_block_master
  import jpeg_axi_pkg::*;
#(
  parameter int                        C_AXI_DATA_WIDTH = 32,
  parameter int                        C_AXI_ADDR_WIDTH = 32,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                        PIXEL_COUNT      = 64,
  parameter int                        RES_COUNT        = 64,
  parameter int                        POLL_LIMIT       = 1024
) (
  input  logic                          axi_aclk,
  input  logic                          axi_areset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [7:0]                    pix_r,
  input  logic [7:0]                    pix_g,
  input  logic [7:0]                    pix_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [31:0]                   res_data,
  output logic [1:0]                    res_comp,
  output logic [5:0]                    res_index,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;

  state_t                 state;
  comp_t                  comp;
  logic [15:0]            pix_cnt;
  logic [15:0]            wr_idx;     // 3*pixel + component
  logic [5:0]             res_n;
  logic [7:0]             g_q;
  logic [7:0]             b_q;
`ifdef JPEG_AXIM_POLL_TIMEOUT_EN
  logic [15:0]            poll_cnt;
`endif

  logic                   req;
  logic                   req_we;
  logic [AW-1:0]          req_addr;
  logic [DW-1:0]          req_wdata;
  logic                   xact_ack;
  logic [DW-1:0]          xact_rdata;
  logic                   xact_err;

  function automatic logic [AW-1:0] rgb_addr(input logic [15:0] idx);
    return BASE_ADDR + AW'(RGB_OFF) + AW'({idx, 2'b00});
  endfunction

  function automatic logic [AW-1:0] res_addr(input comp_t c, input logic [5:0] n);
    return BASE_ADDR + AW'(res_offset(c)) + AW'({n, 2'b00});
  endfunction

  jpeg_axil_xact #(
    .C_AXI_DATA_WIDTH (DW),
    .C_AXI_ADDR_WIDTH (AW)
  ) u_xact (
    .axi_aclk      (axi_aclk),
    .axi_areset    (axi_areset),
    .req           (req),
    .we            (req_we),
    .addr          (req_addr),
    .wdata         (req_wdata),
    .ack           (xact_ack),
    .rdata         (xact_rdata),
    .resp_err      (xact_err),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  // The *_AW_W / *_AR states hand over to their response-wait state once the
  // engine raises bready / rready; the response-wait state then consumes ack.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      pix_ready <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_comp  <= '0;
      res_index <= '0;
      comp      <= COMP_Y;
      pix_cnt   <= '0;
      wr_idx    <= '0;
      res_n     <= '0;
      g_q       <= '0;
      b_q       <= '0;
      req       <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
`ifdef JPEG_AXIM_POLL_TIMEOUT_EN
      poll_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      req  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            error     <= 1'b0;
            busy      <= 1'b1;
            comp      <= COMP_Y;
            pix_cnt   <= '0;
            wr_idx    <= '0;
            res_n     <= '0;
`ifdef JPEG_AXIM_POLL_TIMEOUT_EN
            poll_cnt  <= '0;
`endif
            pix_ready <= 1'b1;
            state     <= ST_PIX;
          end
        end
        ST_PIX: begin
          if (pix_valid && pix_ready) begin
            pix_ready <= 1'b0;
            g_q       <= pix_g;
            b_q       <= pix_b;
            comp      <= COMP_Y;
            req       <= 1'b1;
            req_we    <= 1'b1;
            req_addr  <= rgb_addr(wr_idx);
            req_wdata <= DW'(pix_r);
            state     <= ST_AW_W;
          end
        end
        ST_AW_W: if (m_axi_bready) state <= ST_B;
        ST_B: begin
          if (xact_ack) begin
            if (xact_err) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else if (comp != COMP_CR) begin
              comp      <= comp_t'(comp + 2'd1);
              wr_idx    <= wr_idx + 16'd1;
              req       <= 1'b1;
              req_we    <= 1'b1;
              req_addr  <= rgb_addr(wr_idx + 16'd1);
              req_wdata <= (comp == COMP_Y) ? DW'(g_q) : DW'(b_q);
              state     <= ST_AW_W;
            end else if (pix_cnt == 16'(PIXEL_COUNT - 1)) begin
              req       <= 1'b1;
              req_we    <= 1'b1;
              req_addr  <= BASE_ADDR + AW'(CTRL_OFF);
              req_wdata <= DW'(CTRL_START);
              state     <= ST_CTRL_AW_W;
            end else begin
              pix_cnt   <= pix_cnt + 16'd1;
              wr_idx    <= wr_idx + 16'd1;
              pix_ready <= 1'b1;
              state     <= ST_PIX;
            end
          end
        end
        ST_CTRL_AW_W: if (m_axi_bready) state <= ST_CTRL_B;
        ST_CTRL_B: begin
          if (xact_ack) begin
            if (xact_err) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              req      <= 1'b1;
              req_we   <= 1'b0;
              req_addr <= BASE_ADDR + AW'(STATUS_OFF);
              state    <= ST_POLL_AR;
            end
          end
        end
        ST_POLL_AR: if (m_axi_rready) state <= ST_POLL_R;
        ST_POLL_R: begin
          if (xact_ack) begin
            if (xact_err) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else if (xact_rdata[STATUS_DONE_BIT]) begin
              comp     <= COMP_Y;
              res_n    <= '0;
              req      <= 1'b1;
              req_we   <= 1'b0;
              req_addr <= res_addr(COMP_Y, 6'd0);
              state    <= ST_RD_AR;
`ifdef JPEG_AXIM_POLL_TIMEOUT_EN
            end else if (poll_cnt + 16'd1 >= 16'(POLL_LIMIT)) begin
              poll_cnt <= poll_cnt + 16'd1;
              error    <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_IDLE;
`endif
            end else begin
`ifdef JPEG_AXIM_POLL_TIMEOUT_EN
              poll_cnt <= poll_cnt + 16'd1;
`endif
              req      <= 1'b1;
              req_we   <= 1'b0;
              req_addr <= BASE_ADDR + AW'(STATUS_OFF);
              state    <= ST_POLL_AR;
            end
          end
        end
        ST_RD_AR: if (m_axi_rready) state <= ST_RD_R;
        ST_RD_R: begin
          if (xact_ack) begin
            if (xact_err) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              res_data  <= xact_rdata[31:0];
              res_comp  <= comp;
              res_index <= res_n;
              res_valid <= 1'b1;
              state     <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (res_n == 6'(RES_COUNT - 1)) begin
              if (comp == COMP_CR) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_IDLE;
              end else begin
                comp     <= comp_t'(comp + 2'd1);
                res_n    <= '0;
                req      <= 1'b1;
                req_we   <= 1'b0;
                req_addr <= res_addr(comp_t'(comp + 2'd1), 6'd0);
                state    <= ST_RD_AR;
              end
            end else begin
              res_n    <= res_n + 6'd1;
              req      <= 1'b1;
              req_we   <= 1'b0;
              req_addr <= res_addr(comp, res_n + 6'd1);
              state    <= ST_RD_AR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_axi_block_master.sv
module tb_jpeg_axi_block_master;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int NPIX = 8;
  localparam int NRES = 8;

  logic        clk = 1'b0;
  logic        axi_areset;
  logic        start, pix_valid, res_ready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        busy, done, error, pix_ready, res_valid;
  logic [31:0] res_data;
  logic [1:0]  res_comp;
  logic [5:0]  res_index;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  jpeg_axi_block_master #(
    .C_AXI_DATA_WIDTH (32),
    .C_AXI_ADDR_WIDTH (32),
    .BASE_ADDR        (BASE),
    .PIXEL_COUNT      (NPIX),
    .RES_COUNT        (NRES),
    .POLL_LIMIT       (8)
  ) dut (
    .axi_aclk (clk), .axi_areset (axi_areset),
    .start (start), .busy (busy), .done (done), .error (error),
    .pix_valid (pix_valid), .pix_ready (pix_ready),
    .pix_r (pix_r), .pix_g (pix_g), .pix_b (pix_b),
    .res_valid (res_valid), .res_ready (res_ready), .res_data (res_data),
    .res_comp (res_comp), .res_index (res_index),
    .m_axi_awaddr (awaddr), .m_axi_awvalid (awvalid), .m_axi_awready (awready),
    .m_axi_wdata (wdata), .m_axi_wstrb (wstrb), .m_axi_wvalid (wvalid),
    .m_axi_wready (wready), .m_axi_bresp (bresp), .m_axi_bvalid (bvalid),
    .m_axi_bready (bready), .m_axi_araddr (araddr), .m_axi_arvalid (arvalid),
    .m_axi_arready (arready), .m_axi_rdata (rdata), .m_axi_rresp (rresp),
    .m_axi_rvalid (rvalid), .m_axi_rready (rready)
  );

  // AXI-Lite slave model with programmable AW/W delays, a status register
  // that reports not-done a programmable number of times, and a write log.
  logic        clr;
  int          aw_dly, w_dly, err_at, stat_zeros;
  int          aw_cnt, w_cnt, wr_cnt, rd_cnt, b_cnt, stat_cnt, done_cnt;
  logic        have_aw, have_w;
  logic [31:0] aw_q, w_q;
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  logic [31:0] rd_addr [0:255];
  int          aw_hold [0:63];
  int          w_hold  [0:63];

  assign awready = awvalid && (aw_cnt == aw_dly);
  assign wready  = wvalid && (w_cnt == w_dly);
  assign arready = arvalid;

  always @(posedge clk) begin
    if (clr) begin
      aw_cnt <= 0; w_cnt <= 0; wr_cnt <= 0; rd_cnt <= 0; b_cnt <= 0;
      stat_cnt <= 0; done_cnt <= 0; have_aw <= 1'b0; have_w <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00;
      rdata <= '0; aw_q <= '0; w_q <= '0;
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (awvalid) begin
        if (awready) begin
          aw_q <= awaddr; have_aw <= 1'b1; aw_hold[wr_cnt] <= aw_cnt + 1; aw_cnt <= 0;
        end else aw_cnt <= aw_cnt + 1;
      end
      if (wvalid) begin
        if (wready) begin
          w_q <= wdata; have_w <= 1'b1; w_hold[wr_cnt] <= w_cnt + 1; w_cnt <= 0;
        end else w_cnt <= w_cnt + 1;
      end
      if (bvalid) begin
        if (bready) begin bvalid <= 1'b0; b_cnt <= b_cnt + 1; end
      end else if (have_aw && have_w) begin
        wr_addr[wr_cnt] <= aw_q;
        wr_data[wr_cnt] <= w_q;
        bresp   <= (wr_cnt == err_at) ? 2'b10 : 2'b00;
        bvalid  <= 1'b1;
        wr_cnt  <= wr_cnt + 1;
        have_aw <= 1'b0;
        have_w  <= 1'b0;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        if (rd_cnt < 256) rd_addr[rd_cnt] <= araddr;
        rd_cnt <= rd_cnt + 1;
        if (araddr == BASE + 32'h4) begin
          rdata    <= (stat_cnt < stat_zeros) ? 32'h0 : 32'h2;
          stat_cnt <= stat_cnt + 1;
        end else rdata <= 32'hA500_0000 | araddr;
        rresp  <= 2'b00;
        rvalid <= 1'b1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic clear_slave();
    clr = 1'b1; tick(1); clr = 1'b0;
  endtask

  task automatic feed_pixels(input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) begin
      for (int k = 0; k < 200 && !pix_ready; k++) tick(1);
      check("pix_ready_wait", {31'd0, pix_ready}, 32'd1);
      pix_r = 8'(i); pix_g = 8'(2 * i); pix_b = 8'(3 * i);
      pix_valid = 1'b1; tick(1); pix_valid = 1'b0;
    end
  endtask

  initial begin
    int bad, hold_bad;
    logic [31:0] exp_v, d0;
    axi_areset = 1'b1; clr = 1'b1; start = 1'b0; pix_valid = 1'b0; res_ready = 1'b0;
    pix_r = '0; pix_g = '0; pix_b = '0;
    aw_dly = 0; w_dly = 0; err_at = -1; stat_zeros = 4;
    tick(3);
    // --- reset state ---
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
    check("rst_awaddr", awaddr, 32'd0);
    axi_areset = 1'b0; clr = 1'b0; tick(2);
    check("idle_pix_ready", {31'd0, pix_ready}, 32'd0);

    // --- full block: 0-wait slave, status done on 5th read, res stall ---
    clear_slave();
    pulse_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    feed_pixels(0, 3);
    pulse_start();                       // ignored while busy
    feed_pixels(3, NPIX - 3);
    bad = 0; hold_bad = 0;
    for (int c = 0; c < 3; c++) begin
      for (int n = 0; n < NRES; n++) begin
        for (int k = 0; k < 300 && !res_valid; k++) tick(1);
        case (c)
          0: exp_v = BASE + 32'h240 + 32'(4 * n);
          1: exp_v = BASE + 32'h2C0 + 32'(4 * n);
          default: exp_v = BASE + 32'h340 + 32'(4 * n);
        endcase
        exp_v = 32'hA500_0000 | exp_v;
        if (!res_valid || res_data !== exp_v || res_comp !== 2'(c) || res_index !== 6'(n)) bad++;
        if (c == 1 && n == 7) begin
          d0 = res_data;
          for (int k = 0; k < 10; k++) begin
            tick(1);
            if (!res_valid || res_data !== d0 || res_comp !== 2'd1 || res_index !== 6'd7) hold_bad++;
          end
          check("hold_stable", 32'(hold_bad), 32'd0);
          check("hold_comp", {30'd0, res_comp}, 32'd1);
          check("hold_index", {26'd0, res_index}, 32'd7);
          check("hold_data", res_data, 32'hA500_12DC);
        end
        res_ready = 1'b1; tick(1); res_ready = 1'b0;
        if (c == 2 && n == NRES - 1) check("done_pulse", {31'd0, done}, 32'd1);
      end
    end
    check("result_words_bad", 32'(bad), 32'd0);
    tick(3);
    check("done_count", 32'(done_cnt), 32'd1);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("wr_count", 32'(wr_cnt), 32'(3 * NPIX + 1));
    bad = 0;
    for (int i = 0; i < NPIX; i++)
      for (int k = 0; k < 3; k++)
        if (wr_addr[3*i+k] !== BASE + 32'h40 + 32'(4 * (3 * i + k)) ||
            wr_data[3*i+k] !== 32'((k + 1) * i)) bad++;
    check("pixel_writes_bad", 32'(bad), 32'd0);
    check("pix5_g_addr", wr_addr[16], BASE + 32'h80);
    check("pix5_g_data", wr_data[16], 32'd10);
    check("ctrl_addr", wr_addr[3*NPIX], BASE);
    check("ctrl_data", wr_data[3*NPIX], 32'h1);
    bad = 0;
    for (int i = 0; i < 5; i++) if (rd_addr[i] !== BASE + 32'h4) bad++;
    check("status_reads_bad", 32'(bad), 32'd0);
    check("first_y_read", rd_addr[5], BASE + 32'h240);
    check("rd_count", 32'(rd_cnt), 32'(5 + 3 * NRES));

    // --- AW delayed, W immediate; then reset mid-transaction ---
    aw_dly = 2; w_dly = 0;
    clear_slave();
    pulse_start();
    feed_pixels(0, 1);
    for (int k = 0; k < 100 && b_cnt < 1; k++) tick(1);
    check("aw_hold", 32'(aw_hold[0]), 32'd3);
    check("w_hold", 32'(w_hold[0]), 32'd1);
    check("b_count", 32'(b_cnt), 32'd1);
    for (int k = 0; k < 100 && !awvalid; k++) tick(1);
    check("second_aw_pending", {31'd0, awvalid}, 32'd1);
    axi_areset = 1'b1; #1;
    check("async_rst_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    tick(1); axi_areset = 1'b0; clear_slave(); tick(10);
    check("post_rst_quiet", {28'd0, awvalid, wvalid, arvalid, busy}, 32'd0);
    check("post_rst_wr_count", 32'(wr_cnt), 32'd0);

    // --- SLVERR on third write ---
    aw_dly = 0; err_at = 2;
    clear_slave();
    pulse_start();
    feed_pixels(0, 1);
    for (int k = 0; k < 100 && !error; k++) tick(1);
    check("bresp_error", {31'd0, error}, 32'd1);
    check("bresp_busy", {31'd0, busy}, 32'd0);
    check("bresp_wr_count", 32'(wr_cnt), 32'd3);
    tick(5);
    check("bresp_no_done", 32'(done_cnt), 32'd0);
    check("bresp_error_sticky", {31'd0, error}, 32'd1);
    pulse_start();
    check("restart_clears_error", {31'd0, error}, 32'd0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    axi_areset = 1'b1; tick(1); axi_areset = 1'b0; err_at = -1;

    // --- status never done ---
    stat_zeros = 1000000;
    clear_slave();
    pulse_start();
    feed_pixels(0, NPIX);
`ifdef JPEG_AXIM_POLL_TIMEOUT_EN
    for (int k = 0; k < 3000 && !error; k++) tick(1);
    check("poll_timeout_error", {31'd0, error}, 32'd1);
    check("poll_timeout_reads", 32'(rd_cnt), 32'd8);
    check("poll_timeout_busy", {31'd0, busy}, 32'd0);
`else
    for (int k = 0; k < 3000 && rd_cnt < 100; k++) tick(1);
    check("poll_reached_100", {31'd0, rd_cnt >= 100}, 32'd1);
    check("poll_still_busy", {31'd0, busy}, 32'd1);
    check("poll_no_error", {31'd0, error}, 32'd0);
`endif
    axi_areset = 1'b1; tick(1); axi_areset = 1'b0; tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jpeg_axi_block_master.md
JPEG_AXI_BLOCK_MASTER -- requirements
Module: jpeg_axi_block_master

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32, AXI data width.
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameters BASE_ADDR, default 0, byte base of the target compressor register block.
REQ-004 SHALL have parameters PIXEL_COUNT, default 64; RES_COUNT, default 64, result words read per component.
REQ-005 SHALL have parameter POLL_LIMIT, default 1024, max status reads before timeout.
REQ-006 Ports: axi_aclk in 1, clock; axi_areset in 1, reset. One clock; reset is asynchronous and active-high.
REQ-007 Ports: start in 1, pulse to begin a block; busy out 1; done out 1, one-cycle pulse; error out 1, sticky.
REQ-008 Ports: pix_valid in 1; pix_ready out 1; pix_r, pix_g, pix_b in 8 each, pixel stream.
REQ-009 Ports: res_valid out 1; res_ready in 1; res_data out 32; res_comp out 2 (0=Y, 1=Cb, 2=Cr); res_index out 6.
REQ-010 Ports: full AXI4-Lite master set m_axi_aw*/w*/b*/ar*/r* (addr, valid, ready, wdata, wstrb, bresp, rdata, rresp).

Function
REQ-011 SHALL be an FSM: IDLE, PIX, AW_W, B, CTRL_AW_W, CTRL_B, POLL_AR, POLL_R, RD_AR, RD_R, OUT.
REQ-012 In IDLE, start=1 SHALL clear error, counters, assert busy, go to PIX; start while busy SHALL be ignored.
REQ-013 PIX: pix_ready=1; on pix_valid&&pix_ready capture r,g,b, go to AW_W; pixel i component k SHALL write byte addr BASE_ADDR+0x40+4*(3*i+k), wdata {24'd0,value}, wstrb 4'hF.
REQ-014 AW_W: awvalid and wvalid SHALL assert together; each SHALL drop independently on its own handshake; state exits only when both accepted.
REQ-015 B: bready=1; on bvalid, k advances 0-1-2 then next pixel; after pixel PIXEL_COUNT-1 component 2 go to CTRL_AW_W.
REQ-016 CTRL_AW_W/CTRL_B SHALL write 0x1 to BASE_ADDR+0x00, then go to POLL_AR.
REQ-017 POLL_AR/POLL_R SHALL read BASE_ADDR+0x04; rdata[1]=1 goes to RD_AR, else re-poll and increment poll counter.
REQ-018 RD_AR/RD_R SHALL read Y words at BASE_ADDR+0x240+4*n, Cb at +0x2C0+4*n, Cr at +0x340+4*n, n=0..RES_COUNT-1.
REQ-019 OUT SHALL hold res_valid with data, comp, index stable until res_ready; last Cr word accepted pulses done, returns to IDLE.
REQ-020 At most one outstanding AXI transaction; rready/bready SHALL be 1 only in R/B-wait states.
REQ-021 Any bresp or rresp != 2'b00 SHALL set error, drop busy, go to IDLE without done.
REQ-022 arvalid/awvalid/wvalid SHALL never deassert before handshake; address/data stable while valid.

Reset
REQ-023 On axi_areset all valids, pix_ready, res_valid, busy, done, error SHALL be 0, addr/data 0, FSM IDLE, counters 0, immediately and asynchronously.
REQ-024 Reset mid-transaction SHALL abandon it; no completion is awaited after release.

Configuration
REQ-025 With JPEG_AXIM_POLL_TIMEOUT_EN defined, poll counter reaching POLL_LIMIT SHALL set error and return to IDLE.
REQ-026 Without JPEG_AXIM_POLL_TIMEOUT_EN, polling SHALL continue indefinitely; POLL_LIMIT unused, no counter logic.

Structure
REQ-027 Register byte offsets (CTRL 0x00, STATUS 0x04, RGB 0x40, Y 0x240, Cb 0x2C0, Cr 0x340), state enum, and component codes SHALL live in shared package jpeg_axi_pkg.
REQ-028 Single-transaction AXI-Lite engine SHALL be sub-module jpeg_axil_xact (req, we, addr, wdata -> ack, rdata, resp_err).

Verification
REQ-029 Pixel i=(r=i,g=2i,b=3i), 0-wait slave -> 192 writes, pixel 5 G written 10 at 0x40+4*16=0x80, then 0x1 to 0x00.
REQ-030 Slave delays awready 3 cycles and wready 0 -> awvalid held 3 cycles, wvalid drops after 1, single bvalid accepted.
REQ-031 Status returns 0 four times then 0x2 -> exactly 5 reads of 0x04, then first read at 0x240.
REQ-032 res_ready low 10 cycles on Cb index 7 -> res_data/comp=1/index=7 stable; 192 results total, done one pulse.
REQ-033 bresp=2'b10 on third write -> error=1, busy=0, no done, next start clears error.
REQ-034 POLL_TIMEOUT_EN, POLL_LIMIT=8, status never done -> error after 8 reads; without macro, still polling at 100.
